// File: rtl/dualport_1rw1w_be_pkg.sv
// Shared types and helpers for the 1RW+1W byte-enable RAM.
// Holds the clear-sequencer state type and the byte-lane merge function.
package dualport_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_DW = 256;

  function automatic int nb_of(input int dw, input int bw);
    return dw / bw;
  endfunction

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Lane k of the result is new_w's lane k when be[k], else old_w's.
  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_DW-1:0] be,
    input int                bw
  );
    logic [MAX_DW-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      m[i] = be[i / bw];
    end
    return (old_w & ~m) | (new_w & m);
  endfunction

endpackage

// File: rtl/dualport_1rw1w_be_clr_seq.sv
// Post-reset clear sequencer: walks every entry once writing zero.
// Ports: clk, rst_n in; init_busy, clr_we, clr_addr out.
module dp_clr_seq
  import dualport_pkg::*;
#(
  parameter int AW     = 6,
  parameter int CLR_EN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          init_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam state_t RST_ST = (CLR_EN != 0) ? INIT : RUN;

  state_t        st_q;
  state_t        st_d;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= RST_ST;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    clr_we = 1'b0;
    unique case (st_q)
      INIT: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == {AW{1'b1}}) st_d = RUN;
      end
      RUN: begin
        clr_we = 1'b0;
      end
    endcase
  end

  assign clr_addr  = cnt_q;
  assign init_busy = (st_q == INIT);

endmodule

// File: rtl/dualport_1rw1w_be.sv
// Single-clock 1RW+1W RAM with byte-lane enables, collision merge and clear.
// Ports: clk, rst_n; A: ena, wea, addra, dia -> doa, doa_vld;
// B: enb, beb, addrb, dib; status: init_busy, collision.
module dualport_1rw1w_be
  import dualport_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 6,
  parameter int BYTE_W  = 8,
  parameter int OUT_REG = 0,
  parameter int CLR_EN  = 1,
  parameter int PRIO_B  = 1,
  localparam int NB     = DW / BYTE_W,
  localparam int DEPTH  = 1 << AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [NB-1:0] wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dia,
  output logic [DW-1:0] doa,
  output logic          doa_vld,
  input  logic          enb,
  input  logic [NB-1:0] beb,
  input  logic [AW-1:0] addrb,
  input  logic [DW-1:0] dib,
  output logic          init_busy,
  output logic          collision
);

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  dp_clr_seq #(
    .AW     (AW),
    .CLR_EN (CLR_EN)
  ) u_clr (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  logic          run;
  logic          rd;
  logic          we_a;
  logic          we_b;
  logic          same;
  logic          both;
  logic          hit;
  logic [DW-1:0] old_a;
  logic [DW-1:0] old_b;
  logic [DW-1:0] word_a;
  logic [DW-1:0] word_b;
  logic [DW-1:0] word_ab;

  assign run   = ~init_busy;
  assign rd    = run & ena;
  assign we_a  = rd & (|wea);
  assign we_b  = run & enb & (|beb);
  assign same  = (addra == addrb);
  assign both  = we_a & we_b & same;
  assign hit   = rd & enb & same & (|(wea & beb));
  assign old_a = mem[addra];
  assign old_b = mem[addrb];

  assign word_a = DW'(lane_merge(MAX_DW'(old_a), MAX_DW'(dia),
                                 MAX_DW'(wea), BYTE_W));
  assign word_b = DW'(lane_merge(MAX_DW'(old_b), MAX_DW'(dib),
                                 MAX_DW'(beb), BYTE_W));

  // Same-address writes fold into one word: loser first, winner on top,
  // so disjoint lanes merge and overlapping lanes take the winner.
  generate
    if (PRIO_B != 0) begin : g_prio_b
      assign word_ab = DW'(lane_merge(MAX_DW'(word_a), MAX_DW'(dib),
                                      MAX_DW'(beb), BYTE_W));
    end else begin : g_prio_a
      assign word_ab = DW'(lane_merge(MAX_DW'(word_b), MAX_DW'(dia),
                                      MAX_DW'(wea), BYTE_W));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (both) begin
      mem[addra] <= word_ab;
    end else begin
      if (we_a) mem[addra] <= word_a;
      if (we_b) mem[addrb] <= word_b;
    end
  end

  logic          rd_q;
  logic [DW-1:0] doa_q;
  logic          col_q;

  // Read-first: old_a is sampled before this edge's writes land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= 1'b0;
      doa_q <= '0;
      col_q <= 1'b0;
    end else begin
      rd_q  <= rd;
      col_q <= hit;
      if (rd) doa_q <= old_a;
    end
  end

  assign collision = col_q;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic          vld2_q;
      logic [DW-1:0] doa2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld2_q <= 1'b0;
          doa2_q <= '0;
        end else begin
          vld2_q <= rd_q;
          if (rd_q) doa2_q <= doa_q;
        end
      end

      assign doa     = doa2_q;
      assign doa_vld = vld2_q;
    end else begin : g_noreg
      assign doa     = doa_q;
      assign doa_vld = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_dualport_1rw1w_be.sv
// Directed bench for dualport_1rw1w_be: default instance plus an
// OUT_REG=1 / PRIO_B=0 instance driven by the same stimulus.
module tb_dualport_1rw1w_be;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [1:0]  wea;
  logic [5:0]  addra;
  logic [15:0] dia;
  logic        enb;
  logic [1:0]  beb;
  logic [5:0]  addrb;
  logic [15:0] dib;

  logic [15:0] doa0;
  logic        vld0;
  logic        busy0;
  logic        col0;
  logic [15:0] doa1;
  logic        vld1;
  logic        busy1;
  logic        col1;

  int checks;
  int errs;

  dualport_1rw1w_be dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dia       (dia),
    .doa       (doa0),
    .doa_vld   (vld0),
    .enb       (enb),
    .beb       (beb),
    .addrb     (addrb),
    .dib       (dib),
    .init_busy (busy0),
    .collision (col0)
  );

  dualport_1rw1w_be #(
    .OUT_REG (1),
    .PRIO_B  (0)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dia       (dia),
    .doa       (doa1),
    .doa_vld   (vld1),
    .enb       (enb),
    .beb       (beb),
    .addrb     (addrb),
    .dib       (dib),
    .init_busy (busy1),
    .collision (col1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0;
    wea = 2'b00;
    enb = 1'b0;
    beb = 2'b00;
  endtask

  task automatic wr_a(input logic [5:0] a, input logic [15:0] d,
                      input logic [1:0] be);
    ena   = 1'b1;
    wea   = be;
    addra = a;
    dia   = d;
    tick();
    idle();
  endtask

  task automatic wr_b(input logic [5:0] a, input logic [15:0] d,
                      input logic [1:0] be);
    enb   = 1'b1;
    beb   = be;
    addrb = a;
    dib   = d;
    tick();
    idle();
  endtask

  task automatic wr_ab(input logic [5:0] a, input logic [15:0] da,
                       input logic [1:0] ba, input logic [15:0] db,
                       input logic [1:0] bb);
    ena   = 1'b1;
    wea   = ba;
    addra = a;
    dia   = da;
    enb   = 1'b1;
    beb   = bb;
    addrb = a;
    dib   = db;
    tick();
    idle();
  endtask

  task automatic rd(input string tag, input logic [5:0] a,
                    input logic [15:0] e0, input logic [15:0] e1);
    ena   = 1'b1;
    wea   = 2'b00;
    addra = a;
    tick();
    ena = 1'b0;
    check({tag, "_vld0"}, 32'(vld0), 32'd1);
    check({tag, "_doa0"}, 32'(doa0), 32'(e0));
    tick();
    check({tag, "_vld0_off"}, 32'(vld0), 32'd0);
    check({tag, "_vld1"}, 32'(vld1), 32'd1);
    check({tag, "_doa1"}, 32'(doa1), 32'(e1));
  endtask

  int n;
  int vc;

  initial begin
    checks = 0;
    errs   = 0;
    rst_n  = 1'b0;
    idle();
    addra = '0;
    addrb = '0;
    dia   = '0;
    dib   = '0;

    #2;
    check("rst_doa0", 32'(doa0), 32'h0);
    check("rst_vld0", 32'(vld0), 32'd0);
    check("rst_col0", 32'(col0), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd1);
    check("rst_doa1", 32'(doa1), 32'h0);
    check("rst_busy1", 32'(busy1), 32'd1);

    #20;
    rst_n = 1'b1;
    n = 0;
    while (busy0 && n < 200) begin
      tick();
      n++;
    end
    check("init_cycles", 32'(n), 32'd64);
    check("init_done1", 32'(busy1), 32'd0);

    for (int i = 0; i < 64; i++) begin
      rd("clr", 6'(i), 16'h0000, 16'h0000);
    end

    wr_a(6'd5, 16'hABCD, 2'b11);
    wr_b(6'd5, 16'h12EF, 2'b10);
    rd("bytewr", 6'd5, 16'h12CD, 16'h12CD);

    wr_ab(6'd9, 16'h1111, 2'b11, 16'h2222, 2'b11);
    check("col_full0", 32'(col0), 32'd1);
    check("col_full1", 32'(col1), 32'd1);
    tick();
    check("col_pulse0", 32'(col0), 32'd0);
    check("col_pulse1", 32'(col1), 32'd0);
    rd("col_full", 6'd9, 16'h2222, 16'h1111);

    wr_ab(6'd10, 16'h3344, 2'b11, 16'h5566, 2'b01);
    check("col_part0", 32'(col0), 32'd1);
    rd("col_part", 6'd10, 16'h3366, 16'h3344);

    wr_ab(6'd7, 16'h77AA, 2'b01, 16'hBB00, 2'b10);
    check("disj_col0", 32'(col0), 32'd0);
    check("disj_col1", 32'(col1), 32'd0);
    rd("disj", 6'd7, 16'hBBAA, 16'hBBAA);

    wr_a(6'd3, 16'h0055, 2'b11);
    ena   = 1'b1;
    wea   = 2'b00;
    addra = 6'd3;
    enb   = 1'b1;
    beb   = 2'b11;
    addrb = 6'd3;
    dib   = 16'h00AA;
    tick();
    idle();
    check("rf_doa0", 32'(doa0), 32'h0055);
    check("rf_col0", 32'(col0), 32'd0);
    tick();
    check("rf_doa1", 32'(doa1), 32'h0055);
    rd("rf_next", 6'd3, 16'h00AA, 16'h00AA);

    for (int i = 0; i < 4; i++) begin
      wr_a(6'(i), 16'hA000 + 16'(i), 2'b11);
    end
    tick();
    tick();
    for (int k = 1; k <= 6; k++) begin
      ena   = (k <= 4);
      addra = 6'(k - 1);
      tick();
      check("lat_vld0", 32'(vld0), (k <= 4) ? 32'd1 : 32'd0);
      if (k <= 4) check("lat_doa0", 32'(doa0), 32'hA000 + 32'(k - 1));
      check("lat_vld1", 32'(vld1), (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 5)
        check("lat_doa1", 32'(doa1), 32'hA000 + 32'(k - 2));
    end
    idle();

    ena   = 1'b1;
    addra = 6'd2;
    tick();
    idle();
    rst_n = 1'b0;
    #2;
    check("mid_rst_vld1", 32'(vld1), 32'd0);
    check("mid_rst_doa0", 32'(doa0), 32'h0);
    rst_n = 1'b1;
    vc = 0;
    for (int k = 0; k < 20; k++) begin
      ena   = k[0];
      addra = 6'd5;
      tick();
      if (vld0 || vld1) vc++;
    end
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    n = 0;
    while (busy0 && n < 200) begin
      tick();
      n++;
      if (vld0 || vld1) vc++;
      ena = n[0];
    end
    ena = 1'b0;
    check("reinit_cycles", 32'(n), 32'd64);
    check("init_no_vld", 32'(vc), 32'd0);
    tick();
    check("post_init_vld0", 32'(vld0), 32'd0);
    rd("reclr5", 6'd5, 16'h0000, 16'h0000);
    rd("reclr9", 6'd9, 16'h0000, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end

endmodule
